fft8_bitrev_buffer: RTL and testbench



---
 rtl/fft_pkg.sv | 22 ++
 rtl/fft_cplx_bank.sv | 27 ++
 rtl/fft8_bitrev_buffer.sv | 155 +++++++++++++++
 tb/tb_fft8_bitrev_buffer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT front-end reorder buffer.
// Complex samples are raw FP32 bit patterns; nothing here does arithmetic on them.
package fft_pkg;

    localparam int FFT_N     = 8;
    localparam int FFT_LOG2N = 3;
    localparam int FP_W      = 32;

    typedef struct packed {
        logic [FP_W-1:0] re;
        logic [FP_W-1:0] im;
    } cplx_t;

    function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] idx);
        logic [FFT_LOG2N-1:0] rev;
        for (int b = 0; b < FFT_LOG2N; b++) begin
            rev[b] = idx[FFT_LOG2N-1-b];
        end
        return rev;
    endfunction

endpackage

// File: rtl/fft_cplx_bank.sv
// One N-entry complex sample bank: synchronous write port, asynchronous read by index.
module fft_cplx_bank
    import fft_pkg::*;
#(
    parameter  int N  = FFT_N,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  cplx_t         wdata_i,
    input  logic [AW-1:0] raddr_i,
    output cplx_t         rdata_o
);

    cplx_t mem_q [N];

    // NOTE: storage has no reset; validity is tracked by the owner's bank_full flags.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fft8_bitrev_buffer.sv
// Ping-pong reorder buffer: natural-order complex samples in, bit-reversed frames out.
// Optional macro FFT_FRAME_CNT_EN adds a 16-bit drained-frame counter output.
module fft8_bitrev_buffer
    import fft_pkg::*;
#(
    parameter  int N     = FFT_N,
    parameter  int DW    = FP_W,
    localparam int LOG2N = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [DW-1:0]    i_re,
    input  logic [DW-1:0]    i_im,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [DW-1:0]    o_re,
    output logic [DW-1:0]    o_im,
    output logic [LOG2N-1:0] o_idx,
    output logic             o_last
`ifdef FFT_FRAME_CNT_EN
    ,
    output logic [15:0]      o_frame_cnt
`endif
);

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    logic [1:0]       bank_full_q, bank_full_d;
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [LOG2N-1:0] wr_idx_q, wr_idx_d;
    logic [LOG2N-1:0] rd_idx_q, rd_idx_d;
    logic             o_valid_q, o_valid_d;
    logic             o_last_q, o_last_d;
    logic [LOG2N-1:0] o_idx_q, o_idx_d;
    logic [DW-1:0]    o_re_q, o_re_d;
    logic [DW-1:0]    o_im_q, o_im_d;

    logic  wr_fire;
    logic  rd_load;
    cplx_t bank_rdata [2];
    cplx_t rd_data;

    assign o_ready = !bank_full_q[wr_sel_q];
    assign wr_fire = i_valid && o_ready;
    assign rd_load = (!o_valid_q || i_ready) && bank_full_q[rd_sel_q];
    assign rd_data = bank_rdata[rd_sel_q];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_cplx_bank #(.N(N)) u_bank (
            .clk     (clk),
            .we_i    (wr_fire && (wr_sel_q == 1'(b))),
            .waddr_i (wr_idx_q),
            .wdata_i ('{re: i_re, im: i_im}),
            .raddr_i (bitrev(rd_idx_q)),
            .rdata_o (bank_rdata[b])
        );
    end

    // NOTE: every next-state signal takes its hold value first so no latch is inferred.
    always_comb begin
        bank_full_d = bank_full_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        o_valid_d   = o_valid_q;
        o_last_d    = o_last_q;
        o_idx_d     = o_idx_q;
        o_re_d      = o_re_q;
        o_im_d      = o_im_q;

        if (wr_fire) begin
            wr_idx_d = wr_idx_q + 1'b1;
            if (wr_idx_q == LAST_IDX) begin
                bank_full_d[wr_sel_q] = 1'b1;
                wr_sel_d              = !wr_sel_q;
            end
        end

        // Write side never targets a full bank, so this clear cannot collide with the set above.
        if (rd_load) begin
            o_re_d    = rd_data.re;
            o_im_d    = rd_data.im;
            o_idx_d   = rd_idx_q;
            o_last_d  = (rd_idx_q == LAST_IDX);
            o_valid_d = 1'b1;
            rd_idx_d  = rd_idx_q + 1'b1;
            if (rd_idx_q == LAST_IDX) begin
                bank_full_d[rd_sel_q] = 1'b0;
                rd_sel_d              = !rd_sel_q;
            end
        end else if (i_ready) begin
            o_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            bank_full_q <= 2'b00;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            o_valid_q   <= 1'b0;
            o_last_q    <= 1'b0;
            o_idx_q     <= '0;
            o_re_q      <= '0;
            o_im_q      <= '0;
        end else begin
            bank_full_q <= bank_full_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            o_valid_q   <= o_valid_d;
            o_last_q    <= o_last_d;
            o_idx_q     <= o_idx_d;
            o_re_q      <= o_re_d;
            o_im_q      <= o_im_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_last  = o_last_q;
    assign o_idx   = o_idx_q;
    assign o_re    = o_re_q;
    assign o_im    = o_im_q;

`ifdef FFT_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (o_valid_q && i_ready && o_last_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_fft8_bitrev_buffer.sv
// Scoreboard bench for fft8_bitrev_buffer: accepted frames queue their bit-reversed
// expectations, and every visible output is compared against the queue head.
module tb_fft8_bitrev_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_re;
    logic [31:0] i_im;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_re;
    logic [31:0] o_im;
    logic [2:0]  o_idx;
    logic        o_last;
`ifdef FFT_FRAME_CNT_EN
    logic [15:0] o_frame_cnt;
`endif

    always #5 clk = ~clk;

    fft8_bitrev_buffer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_re    (i_re),
        .i_im    (i_im),
        .i_flush (i_flush),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_re    (o_re),
        .o_im    (o_im),
        .o_idx   (o_idx),
        .o_last  (o_last)
`ifdef FFT_FRAME_CNT_EN
        ,
        .o_frame_cnt (o_frame_cnt)
`endif
    );

    typedef struct packed {
        logic [2:0]  idx;
        logic [31:0] re;
        logic [31:0] im;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] frm_re [8];
    logic [31:0] frm_im [8];
    int          frm_cnt;
    int          checks;
    int          errors;
    int          k_next;
    int          run_len;
    int          max_run;
    int          frames_drained;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] rev3(input logic [2:0] s);
        return {s[0], s[1], s[2]};
    endfunction

    // One clock cycle: compare pre-edge outputs, record handshakes, advance to next negedge.
    task automatic tick();
        logic clr, acc, hs;
        exp_t e;
        clr = !rst_n || i_flush;
        acc = i_valid && o_ready && !clr;
        hs  = o_valid && i_ready && !clr;
        if (o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_valid", {63'd0, o_valid}, 64'd0);
            end else begin
                e = sb[0];
                check("out_idx",  {61'd0, o_idx},  {61'd0, e.idx});
                check("out_re",   {32'd0, o_re},   {32'd0, e.re});
                check("out_im",   {32'd0, o_im},   {32'd0, e.im});
                check("out_last", {63'd0, o_last}, {63'd0, e.last});
                if (hs) begin
                    void'(sb.pop_front());
                    if (e.last) frames_drained++;
                end
            end
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (acc) begin
            frm_re[frm_cnt] = i_re;
            frm_im[frm_cnt] = i_im;
            frm_cnt++;
            if (frm_cnt == 8) begin
                for (int s = 0; s < 8; s++) begin
                    e.idx  = 3'(s);
                    e.re   = frm_re[rev3(3'(s))];
                    e.im   = frm_im[rev3(3'(s))];
                    e.last = (s == 7);
                    sb.push_back(e);
                end
                frm_cnt = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (clr) begin
            sb.delete();
            frm_cnt        = 0;
            frames_drained = 0;
        end
    endtask

    task automatic send(input int n, input bit rnd);
        int  got   = 0;
        int  guard = 0;
        logic rdy;
        while (got < n && guard < 200) begin
            i_valid = 1'b1;
            i_re    = rnd ? $urandom : 32'h3F80_0000 + 32'(k_next);
            i_im    = rnd ? $urandom : 32'(k_next);
            rdy     = o_ready;
            tick();
            if (rdy) begin
                got++;
                k_next++;
            end
            guard++;
        end
        i_valid = 1'b0;
        if (got < n) check("send_timeout", 64'(got), 64'(n));
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {63'd0, o_valid}, 64'd0);
        check({tag, "_last"},  {63'd0, o_last},  64'd0);
        check({tag, "_idx"},   {61'd0, o_idx},   64'd0);
        check({tag, "_re"},    {32'd0, o_re},    64'd0);
        check({tag, "_im"},    {32'd0, o_im},    64'd0);
        check({tag, "_ready"}, {63'd0, o_ready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int   ready_low;
        int   acc_cnt;
        logic rdy;

        checks = 0; errors = 0; frm_cnt = 0; k_next = 0;
        run_len = 0; max_run = 0; frames_drained = 0;
        rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        i_re = '0; i_im = '0;
        @(negedge clk);
        idle(2);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single frame: latency and bit-reversed order.
        send(8, 1'b0);
        check("latency_early", {63'd0, o_valid}, 64'd0);
        tick();
        check("latency_first", {63'd0, o_valid}, 64'd1);
        check("first_slot_re", {32'd0, o_re}, 64'h3F80_0000);
        idle(10);
        check("drain_single", 64'(sb.size()), 64'd0);

        // Four back-to-back frames with no bubbles.
        ready_low = 0; max_run = 0; run_len = 0;
        for (int c = 0; c < 32; c++) begin
            if (!o_ready) ready_low++;
            i_valid = 1'b1;
            i_re    = 32'h3F80_0000 + 32'(k_next);
            i_im    = 32'(k_next);
            k_next++;
            tick();
        end
        i_valid = 1'b0;
        idle(12);
        check("stream_ready_low", 64'(ready_low), 64'd0);
        check("stream_valid_run", 64'(max_run), 64'd32);
        check("drain_stream", 64'(sb.size()), 64'd0);

        // Backpressure: both banks fill, outputs hold, then drain losslessly.
        i_ready = 1'b0;
        acc_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            i_valid = 1'b1;
            i_re    = $urandom;
            i_im    = $urandom;
            rdy     = o_ready;
            tick();
            if (rdy) acc_cnt++;
        end
        i_valid = 1'b0;
        check("bp_accepted", 64'(acc_cnt), 64'd16);
        check("bp_ready_low", {63'd0, o_ready}, 64'd0);
        i_ready = 1'b1;
        idle(24);
        check("drain_bp", 64'(sb.size()), 64'd0);

        // Reset mid-frame, then a clean frame starting at slot 0.
        send(5, 1'b0);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        send(8, 1'b0);
        idle(12);
        check("drain_after_reset", 64'(sb.size()), 64'd0);

        // Flush with one frame held and 3 samples pending; flush beats a concurrent write.
        i_ready = 1'b0;
        send(11, 1'b1);
        i_valid = 1'b1;
        i_flush = 1'b1;
        tick();
        i_valid = 1'b0;
        i_flush = 1'b0;
        check("flush_valid", {63'd0, o_valid}, 64'd0);
        check("flush_ready", {63'd0, o_ready}, 64'd1);
        i_ready = 1'b1;
        idle(10);
        check("flush_quiet", {63'd0, o_valid}, 64'd0);
        send(8, 1'b1);
        idle(12);
        check("drain_after_flush", 64'(sb.size()), 64'd0);

`ifdef FFT_FRAME_CNT_EN
        send(24, 1'b0);
        idle(12);
        check("frame_cnt", {48'd0, o_frame_cnt}, 64'(frames_drained));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
